// File: rtl/transfer_sequencer.sv
// Timepulse/phase sequencer and two-port register-transfer arbiter for the service gates.
// Optional: SEQ_STARVE_GUARD_EN adds a port-0 starvation guard.
module transfer_sequencer #(
  parameter int TP_COUNT = 12
`ifdef SEQ_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 2
`endif
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       GO,
  input  logic       REQ0_VALID,
  input  logic [3:0] REQ0_SRC,
  input  logic [3:0] REQ0_DST,
  output logic       REQ0_READY,
  input  logic       REQ1_VALID,
  input  logic [3:0] REQ1_SRC,
  input  logic [3:0] REQ1_DST,
  output logic       REQ1_READY,
  output logic [7:0] R_n,
  output logic [7:0] W_n,
  output logic       CT_n,
  output logic       RT_n,
  output logic       WT_n,
  output logic       T10_n,
  output logic [3:0] TPNUM,
  output logic       ILLEGAL
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [3:0] tp_q, tp_d, tp_nxt;
  logic       inc_q, inc_d;
  logic       stop_q, stop_d;
  logic       rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic [7:0] r_q, r_d, w_q, w_d;
  logic       ct_q, ct_d, rt_q, rt_d, wt_q, wt_d;
  logic       t10_q, t10_d, ill_q, ill_d;
  logic       acc0, acc1, run_d, force0;

  function automatic logic [7:0] dec(input logic [3:0] c);
    case (c)
      4'd1:    dec = 8'hFE;
      4'd2:    dec = 8'hFD;
      4'd3:    dec = 8'hFB;
      4'd4:    dec = 8'hF7;
      4'd5:    dec = 8'hEF;
      4'd6:    dec = 8'hDF;
      4'd7:    dec = 8'hBF;
      4'd8:    dec = 8'h7F;
      default: dec = 8'hFF;
    endcase
  endfunction

  function automatic logic bad(input logic [3:0] c);
    bad = c > 4'd8;
  endfunction

  assign tp_nxt = (tp_q == TP_COUNT[3:0]) ? 4'd1 : tp_q + 4'd1;
  assign acc0 = (ph_q == 2'd3) && rdy0_q && REQ0_VALID;
  assign acc1 = (ph_q == 2'd3) && rdy1_q && REQ1_VALID;

`ifdef SEQ_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force0 = starve_q == SW'(STARVE_LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_RUN && ph_q == 2'd2 && GO) begin
      if (REQ0_VALID && !rdy0_d) begin
        if (!force0) starve_d = starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end
`else
  assign force0 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    tp_d    = tp_q;
    inc_d   = inc_q;
    stop_d  = stop_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    r_d     = r_q;
    w_d     = w_q;
    ill_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (GO) begin
        state_d = ST_RUN;
        ph_d    = 2'd0;
        inc_d   = 1'b0;
        if (inc_q) tp_d = tp_nxt;
      end
    end else begin
      ph_d = ph_q + 2'd1;
      // GO and arbitration are both sampled on entry to PH3
      if (ph_q == 2'd2) begin
        stop_d = !GO;
        if (GO) begin
          if (REQ0_VALID && (!REQ1_VALID || force0)) rdy0_d = 1'b1;
          else if (REQ1_VALID) rdy1_d = 1'b1;
        end
      end
      if (ph_q == 2'd3) begin
        r_d = 8'hFF;
        w_d = 8'hFF;
        if (acc0) begin
          r_d   = dec(REQ0_SRC);
          w_d   = dec(REQ0_DST);
          ill_d = bad(REQ0_SRC) || bad(REQ0_DST);
        end else if (acc1) begin
          r_d   = dec(REQ1_SRC);
          w_d   = dec(REQ1_DST);
          ill_d = bad(REQ1_SRC) || bad(REQ1_DST);
        end
        if (stop_q) begin
          state_d = ST_IDLE;
          ph_d    = 2'd0;
          inc_d   = 1'b1;
          stop_d  = 1'b0;
        end else begin
          tp_d = tp_nxt;
        end
      end
    end
    run_d = state_d == ST_RUN;
    ct_d  = !(run_d && ph_d == 2'd0);
    rt_d  = !(run_d && (ph_d == 2'd1 || ph_d == 2'd2));
    wt_d  = !(run_d && ph_d == 2'd2);
    t10_d = !(run_d && tp_d == 4'd10);
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q  <= ST_IDLE;
      ph_q     <= 2'd0;
      tp_q     <= 4'd1;
      inc_q    <= 1'b0;
      stop_q   <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      r_q      <= 8'hFF;
      w_q      <= 8'hFF;
      ct_q     <= 1'b1;
      rt_q     <= 1'b1;
      wt_q     <= 1'b1;
      t10_q    <= 1'b1;
      ill_q    <= 1'b0;
`ifdef SEQ_STARVE_GUARD_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      tp_q     <= tp_d;
      inc_q    <= inc_d;
      stop_q   <= stop_d;
      rdy0_q   <= rdy0_d;
      rdy1_q   <= rdy1_d;
      r_q      <= r_d;
      w_q      <= w_d;
      ct_q     <= ct_d;
      rt_q     <= rt_d;
      wt_q     <= wt_d;
      t10_q    <= t10_d;
      ill_q    <= ill_d;
`ifdef SEQ_STARVE_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

  assign REQ0_READY = rdy0_q;
  assign REQ1_READY = rdy1_q;
  assign R_n        = r_q;
  assign W_n        = w_q;
  assign CT_n       = ct_q;
  assign RT_n       = rt_q;
  assign WT_n       = wt_q;
  assign T10_n      = t10_q;
  assign TPNUM      = tp_q;
  assign ILLEGAL    = ill_q;

endmodule
